// File: rtl/trig_sequencer_pkg.sv
// Shared constants, types and helpers for the master trigger sequencer.
//   CH_COMMA : idle comma word (K28.5), sent with tokcomma=1
//   HDR_SIG  : header signature carried in W0[15:4]
//   src_e    : trigger source codes carried in W0[1:0]
//   state_e  : sequencer FSM states
//   link_word_t : link word payload (data + comma flag)
package trig_sequencer_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PER_W  = 24;
    localparam int unsigned SIG_W  = 12;

    localparam logic [DATA_W-1:0] CH_COMMA = 16'h00BC;
    localparam logic [SIG_W-1:0]  HDR_SIG  = 12'hF00;
    localparam logic [DATA_W-1:0] CNT_MAX  = 16'hFFFF;

    typedef enum logic [1:0] {
        SRC_NONE = 2'b00,
        SRC_SUM  = 2'b01,
        SRC_SOFT = 2'b10,
        SRC_PER  = 2'b11
    } src_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HDR  = 2'b01,
        ST_TOK  = 2'b10,
        ST_DEAD = 2'b11
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              comma;
    } link_word_t;

    localparam link_word_t LINK_IDLE = '{data: CH_COMMA, comma: 1'b1};

    // Header word W0 = {HDR_SIG, 2'b00, src}
    function automatic logic [DATA_W-1:0] hdr_word(input src_e src);
        return {HDR_SIG, 2'b00, src};
    endfunction

endpackage

// File: rtl/trig_period_gen.sv
// Periodic trigger generator.
//   clk, reset : master clock, synchronous active-high reset
//   en_i       : generator enable
//   period_i   : interval in clk cycles; 0 disables and holds the count at 0
//   tick_c     : combinational tick, high in the cycle the count sits at period-1
module trig_period_gen
    import trig_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [PER_W-1:0] period_i,
    output logic             tick_c
);

    localparam logic [PER_W-1:0] PER_ONE  = PER_W'(1);
    localparam logic [PER_W-1:0] PER_ZERO = PER_W'(0);

    logic [PER_W-1:0] count_q;
    logic [PER_W-1:0] count_d;
    logic             run;

    assign run    = en_i && (period_i != PER_ZERO);
    assign tick_c = run && (count_q == (period_i - PER_ONE));

    // Count up while running, wrap to 0 on tick, park at 0 when stopped
    always_comb begin
        count_d = count_q;
        if (!run) begin
            count_d = PER_ZERO;
        end else if (tick_c) begin
            count_d = PER_ZERO;
        end else begin
            count_d = count_q + PER_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= PER_ZERO;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/trig_sequencer.sv
// Master trigger sequencer for the 64-channel sum path.
// Arbitrates sum / software / periodic triggers, sends a 2-word frame
// (header, token) on the comma/data link, then holds off for dead_time cycles.
//   clk, reset   : master clock, synchronous active-high reset
//   trig_sum     : sum trigger pulse (highest priority)
//   soft_req     : software trigger pulse
//   per_enable   : periodic generator enable
//   per_period   : periodic interval in cycles, 0 = off
//   inhibit      : level, blocks all new requests
//   dead_time    : dead-time length after the frame
//   token_reset  : pulse, clears the token counter
//   tokdata      : link word
//   tokcomma     : 1 = tokdata is comma
//   busy         : high outside IDLE
//   token        : token of the next frame
//   lost_cnt     : saturating count of dropped sum triggers
module trig_sequencer
    import trig_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              trig_sum,
    input  logic              soft_req,
    input  logic              per_enable,
    input  logic [PER_W-1:0]  per_period,
    input  logic              inhibit,
    input  logic [DATA_W-1:0] dead_time,
    input  logic              token_reset,
    output logic [DATA_W-1:0] tokdata,
    output logic              tokcomma,
    output logic              busy,
    output logic [DATA_W-1:0] token,
    output logic [DATA_W-1:0] lost_cnt
);

    localparam logic [DATA_W-1:0] D_ONE  = DATA_W'(1);
    localparam logic [DATA_W-1:0] D_ZERO = DATA_W'(0);

    state_e            state_q,    state_d;
    src_e              src_q,      src_d;
    link_word_t        link_q,     link_d;
    logic              busy_q,     busy_d;
    logic [DATA_W-1:0] token_q,    token_d;
    logic [DATA_W-1:0] lost_q,     lost_d;
    logic [DATA_W-1:0] dead_cnt_q, dead_cnt_d;
    logic              pend_soft_q, pend_soft_d;
    logic              pend_per_q,  pend_per_d;

    logic per_tick_c;
    logic sum_new;
    logic soft_new;
    logic per_new;
    logic req_soft;
    logic req_per;
    logic lost_inc;

    trig_period_gen u_period_gen (
        .clk      (clk),
        .reset    (reset),
        .en_i     (per_enable),
        .period_i (per_period),
        .tick_c   (per_tick_c)
    );

    // Inhibit discards new requests outright; pending bits survive it
    assign sum_new  = trig_sum   && !inhibit;
    assign soft_new = soft_req   && !inhibit;
    assign per_new  = per_tick_c && !inhibit;
    assign req_soft = soft_new || pend_soft_q;
    assign req_per  = per_new  || pend_per_q;

    // A sum trigger is lost whenever it cannot start a frame immediately
    assign lost_inc = trig_sum && (inhibit || (state_q != ST_IDLE));

    // Next-state, arbitration and link word selection
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        link_d      = LINK_IDLE;
        token_d     = token_q;
        lost_d      = lost_q;
        dead_cnt_d  = dead_cnt_q;
        pend_soft_d = pend_soft_q;
        pend_per_d  = pend_per_q;

        case (state_q)
            ST_IDLE: begin
                if (!inhibit) begin
                    if (sum_new) begin
                        state_d     = ST_HDR;
                        src_d       = SRC_SUM;
                        pend_soft_d = req_soft;
                        pend_per_d  = req_per;
                    end else if (req_soft) begin
                        state_d     = ST_HDR;
                        src_d       = SRC_SOFT;
                        pend_soft_d = 1'b0;
                        pend_per_d  = req_per;
                    end else if (req_per) begin
                        state_d     = ST_HDR;
                        src_d       = SRC_PER;
                        pend_per_d  = 1'b0;
                    end
                end
            end
            ST_HDR: begin
                link_d  = '{data: hdr_word(src_q), comma: 1'b0};
                state_d = ST_TOK;
            end
            ST_TOK: begin
                link_d     = '{data: token_q, comma: 1'b0};
                token_d    = token_q + D_ONE;
                dead_cnt_d = dead_time;
                state_d    = (dead_time == D_ZERO) ? ST_IDLE : ST_DEAD;
            end
            ST_DEAD: begin
                if (dead_cnt_q <= D_ONE) begin
                    state_d = ST_IDLE;
                end else begin
                    dead_cnt_d = dead_cnt_q - D_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Requests arriving during a frame queue one deep
        if (state_q != ST_IDLE) begin
            if (soft_new) begin
                pend_soft_d = 1'b1;
            end
            if (per_new) begin
                pend_per_d = 1'b1;
            end
        end

        // Token reset overrides the TOK increment
        if (token_reset) begin
            token_d = D_ZERO;
        end

        if (lost_inc && (lost_q != CNT_MAX)) begin
            lost_d = lost_q + D_ONE;
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            src_q       <= SRC_NONE;
            link_q      <= LINK_IDLE;
            busy_q      <= 1'b0;
            token_q     <= D_ZERO;
            lost_q      <= D_ZERO;
            dead_cnt_q  <= D_ZERO;
            pend_soft_q <= 1'b0;
            pend_per_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            link_q      <= link_d;
            busy_q      <= busy_d;
            token_q     <= token_d;
            lost_q      <= lost_d;
            dead_cnt_q  <= dead_cnt_d;
            pend_soft_q <= pend_soft_d;
            pend_per_q  <= pend_per_d;
        end
    end

    assign tokdata  = link_q.data;
    assign tokcomma = link_q.comma;
    assign busy     = busy_q;
    assign token    = token_q;
    assign lost_cnt = lost_q;

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed testbench for trig_sequencer.
module tb_trig_sequencer;
    import trig_sequencer_pkg::*;

    logic              clk;
    logic              reset;
    logic              trig_sum;
    logic              soft_req;
    logic              per_enable;
    logic [PER_W-1:0]  per_period;
    logic              inhibit;
    logic [DATA_W-1:0] dead_time;
    logic              token_reset;
    logic [DATA_W-1:0] tokdata;
    logic              tokcomma;
    logic              busy;
    logic [DATA_W-1:0] token;
    logic [DATA_W-1:0] lost_cnt;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    trig_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .trig_sum    (trig_sum),
        .soft_req    (soft_req),
        .per_enable  (per_enable),
        .per_period  (per_period),
        .inhibit     (inhibit),
        .dead_time   (dead_time),
        .token_reset (token_reset),
        .tokdata     (tokdata),
        .tokcomma    (tokcomma),
        .busy        (busy),
        .token       (token),
        .lost_cnt    (lost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one active edge, then settle before sampling/driving
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_word(input string tag, input logic [15:0] w, input logic c);
        chk({tag, "_data"}, 32'(tokdata), 32'(w));
        chk({tag, "_comma"}, 32'(tokcomma), 32'(c));
    endtask

    initial begin
        reset       = 1'b1;
        trig_sum    = 1'b0;
        soft_req    = 1'b0;
        per_enable  = 1'b0;
        per_period  = '0;
        inhibit     = 1'b0;
        dead_time   = '0;
        token_reset = 1'b0;

        // 1: reset state, then 100 idle cycles
        cyc(); cyc(); cyc();
        chk("rst_token", 32'(token), 32'h0);
        chk("rst_lost", 32'(lost_cnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk_word("rst_word", 16'h00BC, 1'b1);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            chk_word("idle_word", 16'h00BC, 1'b1);
            chk("idle_busy", 32'(busy), 32'h0);
        end

        // 2: single sum trigger, dead_time=4
        dead_time = 16'd4;
        trig_sum  = 1'b1;
        cyc();                                   // edge k
        trig_sum  = 1'b0;
        chk("t2_busy_k", 32'(busy), 32'h1);
        chk_word("t2_k", 16'h00BC, 1'b1);
        cyc(); chk_word("t2_w0", 16'hF001, 1'b0);
        cyc(); chk_word("t2_w1", 16'h0000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(); chk_word("t2_dead", 16'h00BC, 1'b1);
            if (i < 3) chk("t2_dead_busy", 32'(busy), 32'h1);
        end
        cyc();                                   // edge k+7
        chk("t2_token", 32'(token), 32'h1);
        chk("t2_busy_end", 32'(busy), 32'h0);

        // 3: sum and soft together: soft becomes pending, served after dead time
        trig_sum = 1'b1;
        soft_req = 1'b1;
        cyc();
        trig_sum = 1'b0;
        soft_req = 1'b0;
        cyc(); chk_word("t3_w0a", 16'hF001, 1'b0);
        cyc(); chk_word("t3_w1a", 16'h0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(); chk_word("t3_dead", 16'h00BC, 1'b1);
        end
        cyc(); chk_word("t3_k7", 16'h00BC, 1'b1);
        chk("t3_busy_k7", 32'(busy), 32'h1);
        cyc(); chk_word("t3_w0b", 16'hF002, 1'b0);
        cyc(); chk_word("t3_w1b", 16'h0002, 1'b0);
        chk("t3_token", 32'(token), 32'h3);
        for (int i = 0; i < 6; i++) cyc();
        chk("t3_idle", 32'(busy), 32'h0);

        // 4: sum triggers while busy are dropped and counted
        dead_time = 16'd10;
        trig_sum  = 1'b1;
        cyc();                                   // k: accepted
        cyc();                                   // k+1: HDR, lost
        chk_word("t4_w0", 16'hF001, 1'b0);
        cyc();                                   // k+2: TOK, lost
        trig_sum = 1'b0;
        chk_word("t4_w1", 16'h0003, 1'b0);
        cyc(); cyc();
        trig_sum = 1'b1;
        cyc();                                   // k+5: DEAD, lost
        trig_sum = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cyc(); chk_word("t4_noframe", 16'h00BC, 1'b1);
        end
        chk("t4_lost", 32'(lost_cnt), 32'h3);
        chk("t4_token", 32'(token), 32'h4);

        // lost_cnt saturation, drops caused by inhibit
        force dut.lost_q = 16'hFFFE;
        #1;
        release dut.lost_q;
        inhibit  = 1'b1;
        trig_sum = 1'b1;
        cyc();
        chk("t4_lost_ffff", 32'(lost_cnt), 32'hFFFF);
        cyc(); cyc();
        trig_sum = 1'b0;
        chk("t4_lost_sat", 32'(lost_cnt), 32'hFFFF);
        chk("t4_inh_busy", 32'(busy), 32'h0);
        chk_word("t4_inh_word", 16'h00BC, 1'b1);
        inhibit = 1'b0;
        cyc(); cyc();
        chk("t4_inh_nofr", 32'(busy), 32'h0);

        // reset clears counters mid-run
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst2_token", 32'(token), 32'h0);
        chk("rst2_lost", 32'(lost_cnt), 32'h0);

        // 5: periodic generator, period 50, dead_time 0
        dead_time  = 16'd0;
        per_period = 24'd50;
        per_enable = 1'b1;
        for (int n = 1; n <= 160; n++) begin
            cyc();
            if (n == 51 || n == 101 || n == 151) begin
                chk_word("t5_hdr", 16'hF003, 1'b0);
            end else if (n == 52 || n == 102 || n == 152) begin
                chk_word("t5_tok", 16'((n - 52) / 50), 1'b0);
            end else begin
                chk_word("t5_idle", 16'h00BC, 1'b1);
            end
        end
        inhibit = 1'b1;
        for (int i = 0; i < 200; i++) begin
            cyc(); chk("t5_inh_comma", 32'(tokcomma), 32'h1);
        end
        inhibit    = 1'b0;
        per_enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc(); chk("t5_after_comma", 32'(tokcomma), 32'h1);
        end
        chk("t5_lost", 32'(lost_cnt), 32'h0);
        chk("t5_token", 32'(token), 32'h3);

        // 6: token wrap and token_reset during TOK
        force dut.token_q = 16'hFFFF;
        #1;
        release dut.token_q;
        trig_sum = 1'b1;
        cyc();
        trig_sum = 1'b0;
        cyc(); chk_word("t6_w0", 16'hF001, 1'b0);
        cyc(); chk_word("t6_w1", 16'hFFFF, 1'b0);
        chk("t6_wrap", 32'(token), 32'h0);
        cyc();
        force dut.token_q = 16'h1234;
        #1;
        release dut.token_q;
        trig_sum = 1'b1;
        cyc();
        trig_sum = 1'b0;
        cyc(); chk_word("t6_w0b", 16'hF001, 1'b0);
        token_reset = 1'b1;
        cyc(); chk_word("t6_w1b", 16'h1234, 1'b0);
        chk("t6_tokrst", 32'(token), 32'h0);
        token_reset = 1'b0;
        cyc();
        chk("t6_hold", 32'(token), 32'h0);
        chk_word("t6_idle", 16'h00BC, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
